// File: rtl/vp_keyq_pkg.sv
// Key event queue shared types, key constants and the set-2 scancode to ASCII map.
// Consumers: keyq_fifo, key_event_queue (joystick path enabled by VP_KEYQ_JOY_EN).
package vp_keyq_pkg;

  typedef struct packed {
    logic [7:0] ascii;
    logic       released;
  } key_event_t;

  localparam logic [7:0] KEY_YES   = 8'h11;
  localparam logic [7:0] KEY_NO    = 8'h12;
  localparam logic [7:0] KEY_ENTER = 8'h0A;
  localparam logic [7:0] KEY_BS    = 8'h08;

  // Returns {mapped, ascii}; mapped=0 means the code is discarded.
  function automatic logic [8:0] sc2ascii(input logic [7:0] sc);
    logic [8:0] r;
    r = 9'h000;
    case (sc)
      8'h45: r = {1'b1, 8'h30};
      8'h16: r = {1'b1, 8'h31};
      8'h1E: r = {1'b1, 8'h32};
      8'h26: r = {1'b1, 8'h33};
      8'h25: r = {1'b1, 8'h34};
      8'h2E: r = {1'b1, 8'h35};
      8'h36: r = {1'b1, 8'h36};
      8'h3D: r = {1'b1, 8'h37};
      8'h3E: r = {1'b1, 8'h38};
      8'h46: r = {1'b1, 8'h39};
      8'h1C: r = {1'b1, 8'h61};
      8'h32: r = {1'b1, 8'h62};
      8'h21: r = {1'b1, 8'h63};
      8'h23: r = {1'b1, 8'h64};
      8'h24: r = {1'b1, 8'h65};
      8'h2B: r = {1'b1, 8'h66};
      8'h34: r = {1'b1, 8'h67};
      8'h33: r = {1'b1, 8'h68};
      8'h43: r = {1'b1, 8'h69};
      8'h3B: r = {1'b1, 8'h6A};
      8'h42: r = {1'b1, 8'h6B};
      8'h4B: r = {1'b1, 8'h6C};
      8'h3A: r = {1'b1, 8'h6D};
      8'h31: r = {1'b1, 8'h6E};
      8'h44: r = {1'b1, 8'h6F};
      8'h4D: r = {1'b1, 8'h70};
      8'h15: r = {1'b1, 8'h71};
      8'h2D: r = {1'b1, 8'h72};
      8'h1B: r = {1'b1, 8'h73};
      8'h2C: r = {1'b1, 8'h74};
      8'h3C: r = {1'b1, 8'h75};
      8'h2A: r = {1'b1, 8'h76};
      8'h1D: r = {1'b1, 8'h77};
      8'h22: r = {1'b1, 8'h78};
      8'h35: r = {1'b1, 8'h79};
      8'h1A: r = {1'b1, 8'h7A};
      8'h29: r = {1'b1, 8'h20};
      8'h79: r = {1'b1, 8'h2B};
      8'h7B: r = {1'b1, 8'h2D};
      8'h7C: r = {1'b1, 8'h2A};
      8'h4A: r = {1'b1, 8'h2F};
      8'h55: r = {1'b1, 8'h3D};
      8'h1F: r = {1'b1, KEY_YES};
      8'h27: r = {1'b1, KEY_NO};
      8'h5A: r = {1'b1, KEY_ENTER};
      8'h66: r = {1'b1, KEY_BS};
      default: r = 9'h000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/keyq_fifo.sv
// Key event FIFO: DEPTH entries of key_event_t, sticky overflow on dropped pushes.
// A pop at full frees the slot for a simultaneous push; a pop on empty is ignored.
module keyq_fifo
  import vp_keyq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       i_push,
  input  key_event_t i_data,
  input  logic       i_pop,
  output logic       o_empty,
  output key_event_t o_head,
  output logic       o_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  key_event_t    r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          r_ovf;

  logic w_full;
  logic w_pop;
  logic w_wr;

  assign o_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CNT_FULL);
  assign w_pop   = i_pop && !o_empty;
  assign w_wr    = i_push && (!w_full || w_pop);
  assign o_head  = r_mem[r_rp];
  assign o_ovf   = r_ovf;

  always_ff @(posedge clk_sys) begin
    if (w_wr) r_mem[r_wp] <= i_data;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr)  r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (i_push && !w_wr) r_ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/key_event_queue.sv
// PS/2 and numpad-joystick key events translated to ASCII and queued for vp_keymap.
// Define VP_KEYQ_JOY_EN to include the joystick edge path; otherwise joy_numpad is ignored.
module key_event_queue
  import vp_keyq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [9:0]  joy_numpad,
  input  logic        rx_read_i,
  output logic        rx_data_ready_o,
  output logic [7:0]  rx_ascii_o,
  output logic        rx_released_o,
  output logic        overflow_o
);

  logic       r_armed;
  logic       r_tog;
  logic       r_stg_vld;
  key_event_t r_stg;

  logic [8:0] w_map;
  logic       w_ps2_evt;
  logic       w_joy_evt;
  key_event_t w_joy_ev;
  logic       w_nxt_vld;
  key_event_t w_nxt;
  logic       w_empty;
  key_event_t w_head;
  logic       w_unused;

  assign w_map     = sc2ascii(ps2_key[7:0]);
  assign w_ps2_evt = r_armed && (ps2_key[10] != r_tog) && w_map[8];

`ifdef VP_KEYQ_JOY_EN
  logic [9:0] r_joy;
  logic [9:0] r_pend;
  logic [9:0] w_edge;
  logic [9:0] w_all;
  logic [9:0] w_pick;

  assign w_unused  = ps2_key[8];
  assign w_edge    = r_armed ? (joy_numpad ^ r_joy) : 10'h000;
  assign w_all     = r_pend | w_edge;
  // Isolate the lowest pending bit; PS/2 takes the slot when both compete.
  assign w_pick    = w_all & (~w_all + 10'd1);
  assign w_joy_evt = !w_ps2_evt && (w_all != 10'h000);

  always_comb begin
    w_joy_ev = '0;
    for (int i = 0; i < 10; i++) begin
      if (w_pick[i]) begin
        w_joy_ev.ascii    = (i == 9) ? 8'h30 : 8'h31 + 8'(i);
        w_joy_ev.released = ~joy_numpad[i];
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_joy  <= '0;
      r_pend <= '0;
    end else begin
      r_joy  <= joy_numpad;
      r_pend <= w_joy_evt ? (w_all & ~w_pick) : w_all;
    end
  end
`else
  assign w_unused  = ^{ps2_key[8], joy_numpad};
  assign w_joy_evt = 1'b0;
  assign w_joy_ev  = '0;
`endif

  always_comb begin
    w_nxt_vld = w_ps2_evt || w_joy_evt;
    w_nxt     = w_joy_ev;
    if (w_ps2_evt) begin
      w_nxt.ascii    = w_map[7:0];
      w_nxt.released = ~ps2_key[9];
    end
  end

  // r_armed holds off detection for the first cycle so copies can load.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_armed   <= 1'b0;
      r_tog     <= 1'b0;
      r_stg_vld <= 1'b0;
      r_stg     <= '0;
    end else begin
      r_armed   <= 1'b1;
      r_tog     <= ps2_key[10];
      r_stg_vld <= w_nxt_vld;
      r_stg     <= w_nxt;
    end
  end

  keyq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_sys(clk_sys),
    .reset  (reset),
    .i_push (r_stg_vld),
    .i_data (r_stg),
    .i_pop  (rx_read_i),
    .o_empty(w_empty),
    .o_head (w_head),
    .o_ovf  (overflow_o)
  );

  assign rx_data_ready_o = !w_empty;
  assign rx_ascii_o      = w_empty ? 8'h00 : w_head.ascii;
  assign rx_released_o   = w_empty ? 1'b0 : w_head.released;

endmodule

// File: tb/tb_key_event_queue.sv
// Scoreboard bench for key_event_queue: directed PS/2 and joystick vectors.
module tb_key_event_queue;
  import vp_keyq_pkg::*;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] ps2_key = '0;
  logic [9:0]  joy_numpad = '0;
  logic        rx_read_i = 1'b0;
  logic        rx_data_ready_o;
  logic [7:0]  rx_ascii_o;
  logic        rx_released_o;
  logic        overflow_o;

  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;

  key_event_queue #(
    .DEPTH(8)
  ) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ps2_key        (ps2_key),
    .joy_numpad     (joy_numpad),
    .rx_read_i      (rx_read_i),
    .rx_data_ready_o(rx_data_ready_o),
    .rx_ascii_o     (rx_ascii_o),
    .rx_released_o  (rx_released_o),
    .overflow_o     (overflow_o)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic ps2(input logic [7:0] code, input logic pr,
                     input logic ext = 1'b0);
    ps2_key = {~ps2_key[10], pr, ext, code};
    tick(1);
  endtask

  task automatic ps2_exp(input logic [7:0] code, input logic pr,
                         input logic [7:0] ascii, input logic ext = 1'b0);
    exp_q.push_back({ascii, ~pr});
    ps2(code, pr, ext);
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 40) begin
      if (rx_data_ready_o) begin
        rx_read_i = 1'b1;
        tick(1);
        rx_read_i = 1'b0;
      end else begin
        tick(1);
      end
      guard++;
    end
    chk({name, " left"}, exp_q.size(), 0);
  endtask

  // Monitor: every accepted pop is compared with the scoreboard head.
  always @(negedge clk_sys) begin
    if (!reset && rx_read_i && rx_data_ready_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop act=%0h exp=none", {rx_ascii_o, rx_released_o});
      end else begin
        mon_e = exp_q.pop_front();
        if ({rx_ascii_o, rx_released_o} !== mon_e) begin
          errors++;
          $display("FAIL pop act=%0h exp=%0h",
                   {rx_ascii_o, rx_released_o}, mon_e);
        end
      end
    end
  end

  logic [7:0] vcode [8] = '{8'h45, 8'h29, 8'h55, 8'h7C,
                            8'h1F, 8'h27, 8'h66, 8'h4A};
  logic [7:0] vasc  [8] = '{8'h30, 8'h20, 8'h3D, 8'h2A,
                            8'h11, 8'h12, 8'h08, 8'h2F};
  logic [7:0] ocode [9] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24,
                            8'h2B, 8'h34, 8'h33, 8'h43};

  initial begin
    tick(2);
    chk("rst ready", rx_data_ready_o, 0);
    chk("rst ascii", rx_ascii_o, 0);
    chk("rst rel", rx_released_o, 0);
    chk("rst ovf", overflow_o, 0);
    reset = 1'b0;
    tick(3);

    ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h16};
    exp_q.push_back({8'h31, 1'b0});
    chk("lat n0", rx_data_ready_o, 0);
    tick(1);
    chk("lat n1", rx_data_ready_o, 0);
    tick(1);
    chk("lat n2", rx_data_ready_o, 1);
    chk("lat ascii", rx_ascii_o, 8'h31);
    chk("lat rel", rx_released_o, 0);
    rx_read_i = 1'b1;
    tick(1);
    rx_read_i = 1'b0;
    chk("pop ready", rx_data_ready_o, 0);

    ps2(8'h76, 1'b1);
    tick(4);
    chk("unmapped", rx_data_ready_o, 0);

    for (int i = 0; i < 8; i++)
      ps2_exp(vcode[i], 1'(i % 2), vasc[i], (i == 7));
    tick(2);
    drain("vec");
    chk("vec ovf", overflow_o, 0);

`ifdef VP_KEYQ_JOY_EN
    joy_numpad = 10'h005;
    exp_q.push_back({8'h31, 1'b0});
    exp_q.push_back({8'h33, 1'b0});
    tick(4);
    joy_numpad = 10'h000;
    exp_q.push_back({8'h31, 1'b1});
    exp_q.push_back({8'h33, 1'b1});
    tick(4);
    drain("joy");
`else
    joy_numpad = 10'h005;
    tick(4);
    joy_numpad = 10'h200;
    tick(4);
    joy_numpad = 10'h000;
    tick(4);
    chk("joy off", rx_data_ready_o, 0);
`endif

    for (int i = 0; i < 9; i++) begin
      if (i < 8) exp_q.push_back({8'h61 + 8'(i), 1'(i % 2)});
      ps2(ocode[i], 1'(~i[0]));
    end
    tick(2);
    chk("full ovf", overflow_o, 1);
    chk("full ready", rx_data_ready_o, 1);
    ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h5A};
    exp_q.push_back({KEY_ENTER, 1'b0});
    tick(1);
    rx_read_i = 1'b1;
    tick(1);
    rx_read_i = 1'b0;
    tick(1);
    drain("ovf");
    chk("empty ready", rx_data_ready_o, 0);
    chk("empty ascii", rx_ascii_o, 0);
    chk("empty rel", rx_released_o, 0);
    chk("sticky ovf", overflow_o, 1);

    ps2(8'h32, 1'b1);
    ps2(8'h21, 1'b1);
    ps2(8'h23, 1'b1);
    tick(3);
    chk("pre rst ready", rx_data_ready_o, 1);
    reset = 1'b1;
    ps2_key = {1'b1, 1'b1, 1'b0, 8'h16};
    #1;
    chk("mid rst ready", rx_data_ready_o, 0);
    chk("mid rst ovf", overflow_o, 0);
    chk("mid rst ascii", rx_ascii_o, 0);
    tick(2);
    reset = 1'b0;
    tick(6);
    chk("held toggle", rx_data_ready_o, 0);

    ps2_exp(8'h45, 1'b0, 8'h30);
    tick(3);
    drain("post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=done");
    $fatal(1);
  end

endmodule
